// File: rtl/mem_stage.sv
// Memory-access stage: issues load/store requests on the SRAM-like data bus,
// aligns/extends load data and produces the write-back triple for MEM/WB.
module mem_stage #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      ex_valid,
    input  logic [3:0]                ex_mem_op,
    input  logic [ADDR_WIDTH-1:0]     ex_mem_addr,
    input  logic [DATA_WIDTH-1:0]     ex_store_data,
    input  logic [DATA_WIDTH-1:0]     ex_reg_write_data,
    input  logic [REG_ADDR_WIDTH-1:0] ex_reg_write_addr,
    input  logic                      ex_reg_write_en,
    input  logic                      flush,
    output logic                      data_req,
    output logic                      data_wr,
    output logic [ADDR_WIDTH-1:0]     data_addr,
    output logic [3:0]                data_wstrb,
    output logic [DATA_WIDTH-1:0]     data_wdata,
    input  logic                      data_addr_ok,
    input  logic                      data_data_ok,
    input  logic [DATA_WIDTH-1:0]     data_rdata,
    output logic                      stall_req,
    output logic                      ale,
    output logic [DATA_WIDTH-1:0]     mem_reg_write_data,
    output logic [REG_ADDR_WIDTH-1:0] mem_reg_write_addr,
    output logic                      mem_reg_write_en
);

    localparam logic [3:0] LD_B  = 4'd1;
    localparam logic [3:0] LD_H  = 4'd2;
    localparam logic [3:0] LD_W  = 4'd3;
    localparam logic [3:0] LD_BU = 4'd4;
    localparam logic [3:0] LD_HU = 4'd5;
    localparam logic [3:0] ST_B  = 4'd6;
    localparam logic [3:0] ST_H  = 4'd7;
    localparam logic [3:0] ST_W  = 4'd8;

    typedef enum logic [1:0] {IDLE, ADDR, DATA, DRAIN} state_t;
    state_t state;

    function automatic logic [DATA_WIDTH-1:0] load_extend(
        input logic [3:0] op, input logic [1:0] off, input logic [DATA_WIDTH-1:0] rdata);
        logic signed [7:0]             b;
        logic signed [15:0]            h;
        logic signed [DATA_WIDTH-1:0]  r;
        b = rdata[{off, 3'b000} +: 8];
        h = off[1] ? rdata[31:16] : rdata[15:0];
        case (op)
            LD_B:    r = b;
            LD_H:    r = h;
            LD_BU:   r = {24'd0, b};
            LD_HU:   r = {16'd0, h};
            default: r = rdata;
        endcase
        return r;
    endfunction

    function automatic logic [3:0] store_strobe(input logic [3:0] op, input logic [1:0] off);
        case (op)
            ST_B:    return 4'b0001 << off;
            ST_H:    return off[1] ? 4'b1100 : 4'b0011;
            ST_W:    return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

    function automatic logic [DATA_WIDTH-1:0] store_lanes(
        input logic [3:0] op, input logic [DATA_WIDTH-1:0] d);
        case (op)
            ST_B:    return {4{d[7:0]}};
            ST_H:    return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

    logic [1:0] off;
    logic       is_mem, is_load, is_store, aligned, access;

    assign off      = ex_mem_addr[1:0];
    assign is_mem   = (ex_mem_op >= LD_B) && (ex_mem_op <= ST_W);
    assign is_load  = (ex_mem_op >= LD_B) && (ex_mem_op <= LD_HU);
    assign is_store = (ex_mem_op >= ST_B) && (ex_mem_op <= ST_W);
    always_comb begin
        aligned = 1'b1;
        case (ex_mem_op)
            LD_H, LD_HU, ST_H: aligned = (off[0] == 1'b0);
            LD_W, ST_W:        aligned = (off == 2'b00);
            default:           aligned = 1'b1;
        endcase
    end
    assign access = ex_valid && is_mem && aligned && !flush;

    assign data_wr    = is_store;
    assign data_addr  = {ex_mem_addr[ADDR_WIDTH-1:2], 2'b00};
    assign data_wstrb = store_strobe(ex_mem_op, off);
    assign data_wdata = store_lanes(ex_mem_op, ex_store_data);

    // Request/stall are combinational so the data_ok cycle releases the pipe at once
    always_comb begin
        data_req  = 1'b0;
        stall_req = 1'b0;
        case (state)
            IDLE, ADDR: begin
                data_req  = access;
                stall_req = access;
            end
            DATA:    stall_req = !data_data_ok;
            DRAIN:   stall_req = ex_valid && is_mem;
            default: ;
        endcase
        if (rst) begin
            data_req  = 1'b0;
            stall_req = 1'b0;
        end
    end

    assign ale = ex_valid && is_mem && !aligned && !flush && (state == IDLE) && !rst;

    assign mem_reg_write_en   = ex_valid && ex_reg_write_en && !stall_req && !flush && !ale && !rst;
    assign mem_reg_write_data = rst ? '0 :
                                is_load ? load_extend(ex_mem_op, off, data_rdata) : ex_reg_write_data;
    assign mem_reg_write_addr = rst ? '0 : ex_reg_write_addr;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE:  if (access) state <= data_addr_ok ? DATA : ADDR;
                ADDR: begin
                    if (!access)          state <= IDLE;
                    else if (data_addr_ok) state <= DATA;
                end
                DATA: begin
                    if (data_data_ok) state <= IDLE;
                    else if (flush)   state <= DRAIN;
                end
                DRAIN: if (data_data_ok) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: hand-computed vectors checked by immediate assertions.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid;
    logic [3:0]  ex_mem_op;
    logic [31:0] ex_mem_addr;
    logic [31:0] ex_store_data;
    logic [31:0] ex_reg_write_data;
    logic [4:0]  ex_reg_write_addr;
    logic        ex_reg_write_en;
    logic        flush;
    logic        data_req;
    logic        data_wr;
    logic [31:0] data_addr;
    logic [3:0]  data_wstrb;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;
    logic        stall_req;
    logic        ale;
    logic [31:0] mem_reg_write_data;
    logic [4:0]  mem_reg_write_addr;
    logic        mem_reg_write_en;

    int checks   = 0;
    int failures = 0;

    mem_stage dut (
        .clk(clk), .rst(rst),
        .ex_valid(ex_valid), .ex_mem_op(ex_mem_op), .ex_mem_addr(ex_mem_addr),
        .ex_store_data(ex_store_data), .ex_reg_write_data(ex_reg_write_data),
        .ex_reg_write_addr(ex_reg_write_addr), .ex_reg_write_en(ex_reg_write_en),
        .flush(flush),
        .data_req(data_req), .data_wr(data_wr), .data_addr(data_addr),
        .data_wstrb(data_wstrb), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .stall_req(stall_req), .ale(ale),
        .mem_reg_write_data(mem_reg_write_data), .mem_reg_write_addr(mem_reg_write_addr),
        .mem_reg_write_en(mem_reg_write_en)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic clear();
        ex_valid = 0; ex_mem_op = 0; ex_mem_addr = 0; ex_store_data = 0;
        ex_reg_write_data = 0; ex_reg_write_addr = 0; ex_reg_write_en = 0;
        flush = 0; data_addr_ok = 0; data_data_ok = 0; data_rdata = 0;
    endtask

    task automatic load_seq(input string tag, input logic [3:0] op, input logic [31:0] addr,
                            input logic [31:0] rd, input logic [31:0] exp);
        clear();
        ex_valid = 1; ex_mem_op = op; ex_mem_addr = addr;
        ex_reg_write_en = 1; ex_reg_write_addr = 5'd7; ex_reg_write_data = 32'h5555_5555;
        data_addr_ok = 1;
        #1;
        chk({tag, "_req"}, data_req, 1);
        chk({tag, "_we0"}, mem_reg_write_en, 0);
        nxt();
        data_addr_ok = 0;
        #1;
        chk({tag, "_stall1"}, stall_req, 1);
        nxt();
        data_data_ok = 1; data_rdata = rd;
        #1;
        chk({tag, "_stall2"}, stall_req, 0);
        chk({tag, "_we"}, mem_reg_write_en, 1);
        chk({tag, "_data"}, mem_reg_write_data, exp);
        nxt();
        clear();
    endtask

    initial begin
        clear();
        rst = 1;
        // A load presented during reset must not produce any activity
        ex_valid = 1; ex_mem_op = 4'd3; ex_mem_addr = 32'h1000;
        ex_reg_write_en = 1; data_addr_ok = 1;
        nxt();
        nxt();
        chk("rst_req", data_req, 0);
        chk("rst_stall", stall_req, 0);
        chk("rst_ale", ale, 0);
        chk("rst_we", mem_reg_write_en, 0);
        chk("rst_wdata", mem_reg_write_data, 0);
        chk("rst_waddr", mem_reg_write_addr, 0);
        rst = 0;
        clear();
        nxt();

        // LD_W basic: two-cycle latency
        ex_valid = 1; ex_mem_op = 4'd3; ex_mem_addr = 32'h1000;
        ex_reg_write_en = 1; ex_reg_write_addr = 5'd5; data_addr_ok = 1;
        #1;
        chk("ldw_c0_req", data_req, 1);
        chk("ldw_c0_wr", data_wr, 0);
        chk("ldw_c0_addr", data_addr, 32'h1000);
        chk("ldw_c0_wstrb", data_wstrb, 0);
        chk("ldw_c0_stall", stall_req, 1);
        chk("ldw_c0_we", mem_reg_write_en, 0);
        nxt();
        data_addr_ok = 0;
        #1;
        chk("ldw_c1_req", data_req, 0);
        chk("ldw_c1_stall", stall_req, 1);
        chk("ldw_c1_we", mem_reg_write_en, 0);
        nxt();
        data_data_ok = 1; data_rdata = 32'h89AB_CDEF;
        #1;
        chk("ldw_c2_stall", stall_req, 0);
        chk("ldw_c2_we", mem_reg_write_en, 1);
        chk("ldw_c2_data", mem_reg_write_data, 32'h89AB_CDEF);
        chk("ldw_c2_waddr", mem_reg_write_addr, 5'd5);
        nxt();
        clear();
        #1;
        chk("ldw_c3_we", mem_reg_write_en, 0);

        // Load extension
        load_seq("ldb",  4'd1, 32'h1003, 32'h80FF_7F01, 32'hFFFF_FF80);
        load_seq("ldbu", 4'd4, 32'h1003, 32'h80FF_7F01, 32'h0000_0080);
        load_seq("ldhu", 4'd5, 32'h1002, 32'h80FF_7F01, 32'h0000_80FF);
        load_seq("ldh",  4'd2, 32'h1002, 32'h80FF_7F01, 32'hFFFF_80FF);
        load_seq("ldb1", 4'd1, 32'h1001, 32'h80FF_7F01, 32'h0000_007F);

        // ST_H upper half
        ex_valid = 1; ex_mem_op = 4'd7; ex_mem_addr = 32'h2002;
        ex_store_data = 32'h1234_ABCD; ex_reg_write_en = 0; data_addr_ok = 1;
        #1;
        chk("sth_req", data_req, 1);
        chk("sth_wr", data_wr, 1);
        chk("sth_addr", data_addr, 32'h2000);
        chk("sth_wstrb", data_wstrb, 4'b1100);
        chk("sth_wdata", data_wdata, 32'hABCD_ABCD);
        chk("sth_we", mem_reg_write_en, 0);
        nxt();
        data_addr_ok = 0; data_data_ok = 1;
        #1;
        chk("sth_ack_stall", stall_req, 0);
        chk("sth_ack_we", mem_reg_write_en, 0);
        nxt();
        clear();

        // ST_B lane 1
        ex_valid = 1; ex_mem_op = 4'd6; ex_mem_addr = 32'h2001; ex_store_data = 32'h1234_ABCD;
        #1;
        chk("stb_wstrb", data_wstrb, 4'b0010);
        chk("stb_wdata", data_wdata, 32'hCDCD_CDCD);
        chk("stb_stall", stall_req, 1);
        clear();
        ex_valid = 0;
        rst = 1;
        nxt();
        rst = 0;

        // Misaligned LD_W
        ex_valid = 1; ex_mem_op = 4'd3; ex_mem_addr = 32'h1001;
        ex_reg_write_en = 1; ex_reg_write_addr = 5'd9; data_addr_ok = 1;
        #1;
        chk("ale_ale", ale, 1);
        chk("ale_req", data_req, 0);
        chk("ale_stall", stall_req, 0);
        chk("ale_we", mem_reg_write_en, 0);
        nxt();
        // FSM must still be idle: an ALU op writes back immediately
        clear();
        ex_valid = 1; ex_mem_op = 4'd0; ex_reg_write_en = 1;
        ex_reg_write_addr = 5'd3; ex_reg_write_data = 32'hDEAD_BEEF;
        #1;
        chk("alu_ale", ale, 0);
        chk("alu_stall", stall_req, 0);
        chk("alu_we", mem_reg_write_en, 1);
        chk("alu_data", mem_reg_write_data, 32'hDEAD_BEEF);
        chk("alu_waddr", mem_reg_write_addr, 5'd3);
        nxt();
        clear();

        // Flush in DATA, response drained before next load issues
        ex_valid = 1; ex_mem_op = 4'd3; ex_mem_addr = 32'h1000;
        ex_reg_write_en = 1; data_addr_ok = 1;
        nxt();
        data_addr_ok = 0; flush = 1;
        #1;
        chk("fl_c1_we", mem_reg_write_en, 0);
        chk("fl_c1_req", data_req, 0);
        nxt();
        flush = 0; ex_mem_addr = 32'h3000; data_addr_ok = 1;
        #1;
        chk("fl_drain_req", data_req, 0);
        chk("fl_drain_stall", stall_req, 1);
        nxt();
        data_data_ok = 1; data_rdata = 32'hBAD0_BAD0;
        #1;
        chk("fl_dok_req", data_req, 0);
        chk("fl_dok_stall", stall_req, 1);
        chk("fl_dok_we", mem_reg_write_en, 0);
        nxt();
        data_data_ok = 0;
        #1;
        chk("fl_new_req", data_req, 1);
        chk("fl_new_addr", data_addr, 32'h3000);
        nxt();
        data_addr_ok = 0; data_data_ok = 1; data_rdata = 32'h1111_2222;
        #1;
        chk("fl_new_we", mem_reg_write_en, 1);
        chk("fl_new_data", mem_reg_write_data, 32'h1111_2222);
        nxt();
        clear();

        // ST_W with addr_ok withheld three cycles
        ex_valid = 1; ex_mem_op = 4'd8; ex_mem_addr = 32'h4000; ex_store_data = 32'hCAFE_F00D;
        for (int i = 0; i < 4; i++) begin
            data_addr_ok = (i == 3);
            #1;
            chk($sformatf("stw_req%0d", i), data_req, 1);
            chk($sformatf("stw_stall%0d", i), stall_req, 1);
            chk($sformatf("stw_addr%0d", i), data_addr, 32'h4000);
            chk($sformatf("stw_wstrb%0d", i), data_wstrb, 4'b1111);
            chk($sformatf("stw_wdata%0d", i), data_wdata, 32'hCAFE_F00D);
            nxt();
        end
        data_addr_ok = 0;
        #1;
        chk("stw_data_req", data_req, 0);
        nxt();
        data_data_ok = 1;
        #1;
        chk("stw_ack_stall", stall_req, 0);
        nxt();
        clear();

        // Reset while in ADDR
        ex_valid = 1; ex_mem_op = 4'd3; ex_mem_addr = 32'h5000; ex_reg_write_en = 1;
        nxt();
        nxt();
        rst = 1;
        #1;
        chk("rstaddr_req", data_req, 0);
        chk("rstaddr_stall", stall_req, 0);
        nxt();
        rst = 0;
        clear();
        #1;
        chk("rstaddr_idle_req", data_req, 0);
        chk("rstaddr_idle_stall", stall_req, 0);
        nxt();
        load_seq("post_rst", 4'd3, 32'h5000, 32'h0BAD_CAFE, 32'h0BAD_CAFE);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage of the scalar pipeline, between the EX/MEM register and the MEM/WB register.
- Issues load/store requests on the data-SRAM-like bus (req/addr_ok/data_ok) and aligns and extends load data.
- Produces the register write-back triple captured by the MEM/WB register every cycle.
- Stalls upstream while an access is outstanding, and inserts a bubble (write enable 0) downstream.

Parameters:
- DATA_WIDTH, 32, register and data-bus width (only 32 supported).
- ADDR_WIDTH, 32, memory address width.
- REG_ADDR_WIDTH, 5, register-file address width.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- ex_valid  in  1  EX/MEM slot holds a valid instruction
- ex_mem_op  in  4  0 none, 1 LD_B, 2 LD_H, 3 LD_W, 4 LD_BU, 5 LD_HU, 6 ST_B, 7 ST_H, 8 ST_W; 9-15 treated as none
- ex_mem_addr  in  ADDR_WIDTH  effective address
- ex_store_data  in  DATA_WIDTH  store source register value
- ex_reg_write_data  in  DATA_WIDTH  ALU result for non-load instructions
- ex_reg_write_addr  in  REG_ADDR_WIDTH  destination register
- ex_reg_write_en  in  1  destination write enable
- flush  in  1  discard the current instruction and any in-flight response
- data_req  out  1  bus request
- data_wr  out  1  1 store, 0 load
- data_addr  out  ADDR_WIDTH  word-aligned address {ex_mem_addr[31:2],2'b00}
- data_wstrb  out  4  byte strobes (0 for loads)
- data_wdata  out  DATA_WIDTH  lane-replicated store data
- data_addr_ok  in  1  request accepted this cycle
- data_data_ok  in  1  read data / write acknowledge valid this cycle
- data_rdata  in  DATA_WIDTH  read data
- stall_req  out  1  hold EX/MEM and earlier stages
- ale  out  1  address-misalignment exception, one cycle
- mem_reg_write_data  out  DATA_WIDTH  to MEM/WB
- mem_reg_write_addr  out  REG_ADDR_WIDTH  to MEM/WB
- mem_reg_write_en  out  1  to MEM/WB

Behaviour:
- access = ex_valid && op in 1..8 && aligned && !flush.
- Alignment rules: H ops need addr[0]=0; W ops need addr[1:0]=0; B ops are always aligned.
- Upstream holds all ex_* inputs stable while stall_req=1.
- FSM states: IDLE, ADDR, DATA, DRAIN. Reset puts the FSM in IDLE.
- Reset values: data_req, stall_req, ale and all mem_reg_* outputs are 0 during rst.
- IDLE:
  - data_req = access.
  - access && addr_ok -> DATA.
  - access && !addr_ok -> ADDR.
- ADDR:
  - data_req = 1.
  - addr_ok -> DATA.
  - flush -> IDLE with data_req=0 in that cycle, no request issued.
- DATA:
  - data_req = 0.
  - data_ok -> IDLE.
  - flush && !data_ok -> DRAIN.
  - flush && data_ok -> IDLE, result discarded.
- DRAIN:
  - data_req = 0, result discarded.
  - data_ok -> IDLE.
  - A new access is not issued until the FSM is back in IDLE.
- data_ok is never asserted in the same cycle as the addr_ok of the same request. The block ignores data_ok in IDLE and ADDR.
- stall_req:
  - 1 when access is pending and the FSM is in IDLE/ADDR, or in DATA without data_ok.
  - 1 in DRAIN whenever ex_valid && op != none.
  - Released combinationally in the data_ok cycle so MEM/WB captures the result that cycle.
- Result timing (combinational): mem_reg_write_en = ex_valid && ex_reg_write_en && !stall_req && !flush && !ale.
  - Loads: write data is the extended rdata, valid only in the DATA+data_ok cycle.
  - Others: write data = ex_reg_write_data.
- Minimum load/store latency: 2 cycles (IDLE with addr_ok, then DATA with data_ok).
- Non-memory ops: zero latency, no stall.
- Load extension, lane off = addr[1:0]:
  - B ops take rdata[8off+7:8off]; H ops take rdata[16off[1]+15:16off[1]].
  - LD_B/LD_H sign-extend; LD_BU/LD_HU zero-extend; LD_W passes rdata through.
- Store strobes and data:
  - ST_B: wstrb = 1<<off, wdata = {4{data[7:0]}}.
  - ST_H: wstrb = off[1] ? 1100 : 0011, wdata = {2{data[15:0]}}.
  - ST_W: wstrb = 1111, wdata = data.
- Misaligned op with ex_valid && !flush: ale=1 for that cycle, no request, no stall, write_en=0, FSM stays in IDLE.
- rst in any state: FSM goes to IDLE. Any outstanding bus response is the bus owner's concern; the bus is reset together with this block.

Test Plan:
- LD_W addr 0x1000, addr_ok in cycle 0, data_ok+rdata 0x89ABCDEF in cycle 2 -> stall_req 1 in cycles 0-1, 0 in cycle 2; write_en=1, data=0x89ABCDEF in cycle 2 only.
- LD_B addr 0x1003, rdata 0x80FF7F01 -> write data 0xFFFFFF80; LD_BU same -> 0x00000080; LD_HU addr 0x1002 -> 0x000080FF.
- ST_H addr 0x2002, store data 0x1234ABCD -> data_wr=1, wstrb=1100, wdata=0xABCDABCD, write_en=0 (store with ex_reg_write_en=0).
- LD_W addr 0x1001 -> ale=1 for one cycle, data_req=0, stall_req=0, write_en=0.
- Load accepted, flush asserted in DATA, data_ok two cycles later -> FSM goes to DRAIN; result never written; next load's data_req rises only after data_ok.
- addr_ok withheld 3 cycles on ST_W -> data_req held high 4 cycles with stable addr/wstrb/wdata; stall_req high throughout; rst mid-ADDR -> data_req=0 and FSM in IDLE the next cycle.
